// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port RAM: IDLE -> ACCESS -> ACK, one access per three cycles.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module ram_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_wen,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_wen,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              last_gnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              gnt_q,   gnt_d;
   logic              wen_q,   wen_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              tie_winner;
   logic              winner;

   always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      tie_winner = 1'b0;
`else
      tie_winner = ~gnt_q;
`endif
      // A lone requester wins outright; only a tie consults the policy.
      winner = (p0_req && p1_req) ? tie_winner : p1_req;
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first so no path leaves it unassigned (no latch).
      state_d = state_q;
      gnt_d   = gnt_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               state_d = S_ACCESS;
               gnt_d   = winner;
               wen_d   = winner ? p1_wen   : p0_wen;
               addr_d  = winner ? p1_addr  : p0_addr;
               wdata_d = winner ? p1_wdata : p0_wdata;
            end
         end
         S_ACCESS: state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b1;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Write enable decodes straight from state so an async reset kills it mid-cycle.
   assign ram_addr = addr_q;
   assign ram_din  = wdata_q;
   assign ram_wen  = (state_q == S_ACCESS) && wen_q;
   assign busy     = (state_q != S_IDLE);
   assign last_gnt = gnt_q;
   assign p0_ack   = (state_q == S_ACK) && !gnt_q;
   assign p1_ack   = (state_q == S_ACK) &&  gnt_q;
   assign p0_rdata = p0_ack ? ram_dout : '0;
   assign p1_rdata = p1_ack ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: reset, randomized traffic against a transaction-level
// model, table-driven single accesses, and directed pulse/reset/arbitration sequences.
module tb_ram_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              p0_req = 1'b0, p0_wen = 1'b0, p1_req = 1'b0, p1_wen = 1'b0;
   logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
   logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
   logic              p0_ack, p1_ack, ram_wen, busy, last_gnt;
   logic [DATA_W-1:0] p0_rdata, p1_rdata, ram_din;
   logic [DATA_W-1:0] ram_dout = '0;
   logic [ADDR_W-1:0] ram_addr;

   int n_pass = 0;
   int n_total = 0;
   int edge_cnt = 0;

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen), .ram_dout(ram_dout),
      .busy(busy), .last_gnt(last_gnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   // Single-port RAM with registered, write-first output.
   logic [DATA_W-1:0] mem [2048];
   logic [DATA_W-1:0] gold [2048];
   initial for (int i = 0; i < 2048; i++) begin mem[i] = '0; gold[i] = '0; end
   always @(posedge clk) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      ram_dout <= ram_wen ? ram_din : mem[ram_addr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (p == 0) begin p0_req = r; p0_wen = w; p0_addr = a; p0_wdata = d; end
      else        begin p1_req = r; p1_wen = w; p1_addr = a; p1_wdata = d; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_port(0, 0, 0, '0, '0);
      set_port(1, 0, 0, '0, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One access from an idle arbiter; checks the RAM cycle, the ack cycle and the return to idle.
   task automatic do_txn(input int p, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
      set_port(p, 1, w, a, d);
      @(negedge clk);
      check("access_busy", busy, 1);
      check("access_ram_wen", ram_wen, w);
      check("access_ram_addr", ram_addr, a);
      if (w) check("access_ram_din", ram_din, d);
      @(negedge clk);
      check("ack_own", (p == 0) ? p0_ack : p1_ack, 1);
      check("ack_other", (p == 0) ? p1_ack : p0_ack, 0);
      check("ack_rdata", (p == 0) ? p0_rdata : p1_rdata, exp);
      check("ack_ram_wen", ram_wen, 0);
      check("last_gnt", last_gnt, p[0]);
      set_port(p, 0, 0, '0, '0);
      @(negedge clk);
      check("post_ack", p0_ack | p1_ack | busy, 0);
   endtask

   typedef struct {
      int                port;
      logic              wen;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp;
   } vec_t;
   vec_t vecs [8];

   // Transaction-level reference: grants happen on edges at least 3 apart, ack one edge later.
   int                g_edge = -100;
   bit                m_last = 1'b1;
   int                exp_port = 0;
   logic [DATA_W-1:0] exp_data = '0;
   bit                pend [2];
   bit                granted [2];

   task automatic random_cycle();
      int  e;
      bit  r [2];
      bit  w [2];
      logic [ADDR_W-1:0] a [2];
      logic [DATA_W-1:0] d [2];
      int  win;
      @(negedge clk);
      e = edge_cnt;
      check("rnd_busy", busy, (e == g_edge || e == g_edge + 1) ? 1 : 0);
      check("rnd_p0_ack", p0_ack, (e == g_edge + 1 && exp_port == 0) ? 1 : 0);
      check("rnd_p1_ack", p1_ack, (e == g_edge + 1 && exp_port == 1) ? 1 : 0);
      if (e == g_edge + 1) begin
         check("rnd_rdata", (exp_port == 0) ? p0_rdata : p1_rdata, exp_data);
         granted[exp_port] = 0;
      end else begin
         check("rnd_rdata_idle", p0_rdata | p1_rdata, 0);
      end
      if (e == g_edge) check("rnd_last_gnt", last_gnt, m_last);
      for (int p = 0; p < 2; p++) begin
         w[p] = 1'($urandom % 2);
         a[p] = ($urandom % 4 == 0) ? 11'h7FF : 11'($urandom % 8);
         d[p] = $urandom;
         if (granted[p])                      r[p] = 1'($urandom % 2);
         else if (pend[p] && $urandom % 16 == 0) begin pend[p] = 0; r[p] = 0; end
         else if (pend[p]) begin
            r[p] = 1;
            w[p] = (p == 0) ? p0_wen : p1_wen;
            a[p] = (p == 0) ? p0_addr : p1_addr;
            d[p] = (p == 0) ? p0_wdata : p1_wdata;
         end else if ($urandom % 3 == 0) begin pend[p] = 1; r[p] = 1; end
         else r[p] = 0;
         set_port(p, r[p], w[p], a[p], d[p]);
      end
      if (e + 1 >= g_edge + 3 && (r[0] || r[1])) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         win = (r[0] && r[1]) ? 0 : (r[1] ? 1 : 0);
`else
         win = (r[0] && r[1]) ? int'(!m_last) : (r[1] ? 1 : 0);
`endif
         m_last = win[0];
         g_edge = e + 1;
         exp_port = win;
         if (w[win]) gold[a[win]] = d[win];
         exp_data = gold[a[win]];
         pend[win] = 0;
         granted[win] = 1;
      end
   endtask

   initial begin
      int order [4];
      int got;
      int both;
      int wen_cnt;
      int exp_order [4];

      vecs[0] = '{0, 1'b1, 11'h005, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{0, 1'b0, 11'h005, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{0, 1'b1, 11'h7FF, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[3] = '{1, 1'b0, 11'h7FF, 32'h0,        32'hCAFEF00D};
      vecs[4] = '{1, 1'b1, 11'h000, 32'h00000001, 32'h00000001};
      vecs[5] = '{0, 1'b0, 11'h000, 32'h0,        32'h00000001};
      vecs[6] = '{1, 1'b1, 11'h400, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[7] = '{1, 1'b0, 11'h400, 32'h0,        32'hA5A5A5A5};
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif

      // Reset state, then ten idle cycles without any RAM write.
      rst = 1'b1;
      #12;
      check("rst_busy", busy, 0);
      check("rst_last_gnt", last_gnt, 1);
      check("rst_ram_wen", ram_wen, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_acks", p0_ack | p1_ack, 0);
      check("rst_rdata", p0_rdata | p1_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      wen_cnt = 0;
      repeat (10) begin @(negedge clk); wen_cnt += ram_wen; end
      check("idle_ram_writes", wen_cnt, 0);
      check("idle_busy", busy, 0);

      // Randomized two-port traffic.
      repeat (400) random_cycle();
      set_port(0, 0, 0, '0, '0);
      set_port(1, 0, 0, '0, '0);
      repeat (4) @(negedge clk);

      // Table-driven single accesses (includes the 0x005 and 0x7FF cases).
      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].port, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // p1 pulses req only during p0's ACK cycle: it must be ignored.
      set_port(0, 1, 0, 11'h005, '0);
      @(negedge clk);
      @(negedge clk);
      check("pulse_p0_ack", p0_ack, 1);
      set_port(0, 0, 0, '0, '0);
      set_port(1, 1, 0, 11'h005, '0);
      @(negedge clk);
      set_port(1, 0, 0, '0, '0);
      repeat (6) begin
         @(negedge clk);
         check("pulse_no_p1_ack", p1_ack, 0);
         check("pulse_no_busy", busy, 0);
      end

      // Both ports hold read requests: grant order from reset.
      do_reset();
      set_port(0, 1, 0, 11'h005, '0);
      set_port(1, 1, 0, 11'h7FF, '0);
      got = 0;
      both = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         if (p0_ack && p1_ack) both++;
         if (p0_ack) order[got++] = 0;
         else if (p1_ack) order[got++] = 1;
      end
      check("rr_grant_count", got, 4);
      check("rr_both_acks", both, 0);
      for (int i = 0; i < 4; i++) check("rr_order", order[i], exp_order[i]);
      set_port(0, 0, 0, '0, '0);
      set_port(1, 0, 0, '0, '0);
      repeat (4) @(negedge clk);

      // Reset mid-ACCESS of a p1 write: write aborted, no ack, RAM unchanged.
      set_port(1, 1, 1, 11'h7FF, 32'h12345678);
      @(posedge clk);
      #1;
      check("abort_ram_wen_before", ram_wen, 1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_ram_wen_after", ram_wen, 0);
      check("abort_busy", busy, 0);
      check("abort_last_gnt", last_gnt, 1);
      set_port(1, 0, 0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_p1_ack", p1_ack, 0);
      end
      do_txn(1, 0, 11'h7FF, '0, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
